// File: rtl/instruction_decoder.sv
// instruction_decoder: decodes the 8-bit program-memory word into sequencer
// jump controls and datapath enables, owns the zero flag behind dont_jump,
// and latches a sticky halt on a jump-to-self.
// Optional statistics counters are built only when DECODER_STATS_EN is defined.
module instruction_decoder #(
   parameter int unsigned STAT_W = 16
) (
   input  logic              clk,
   input  logic              sync_reset_n,
   input  logic [7:0]        pm_data,
   input  logic [7:0]        pc,
   input  logic              alu_zero,
   output logic              jmp,
   output logic              jmp_nz,
   output logic [3:0]        jmp_addr,
   output logic              dont_jump,
   output logic              ld_en,
   output logic [2:0]        ld_sel,
   output logic [2:0]        src_sel,
   output logic              imm_sel,
   output logic [3:0]        imm,
   output logic              alu_en,
   output logic [2:0]        alu_func,
   output logic              halted
`ifdef DECODER_STATS_EN
   ,
   output logic [STAT_W-1:0] instr_count,
   output logic [STAT_W-1:0] jump_count
`endif
);

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_flag;

   logic w_is_load;
   logic w_is_mov;
   logic w_is_alu;
   logic w_is_jmp;
   logic w_is_jnz;
   logic w_self_jmp;

   // Opcode classification straight from the instruction word
   always_comb begin
      w_is_load  = ~pm_data[7];
      w_is_mov   = (pm_data[7:6] == 2'b10);
      w_is_alu   = (pm_data[7:5] == 3'b110) && (pm_data[1:0] == 2'b00);
      w_is_jmp   = (pm_data[7:4] == 4'hE);
      w_is_jnz   = (pm_data[7:4] == 4'hF);
      w_self_jmp = w_is_jmp && ({pm_data[3:0], 4'h0} == pc);
   end

   // State register; reset is synchronous and dominates everything
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and zero-latency decode; reset low forces all enables off
   always_comb begin
      w_state_nxt = r_state;
      ld_en       = 1'b0;
      alu_en      = 1'b0;
      jmp         = 1'b0;
      jmp_nz      = 1'b0;
      ld_sel      = pm_data[7] ? pm_data[5:3] : pm_data[6:4];
      src_sel     = pm_data[2:0];
      imm_sel     = ~pm_data[7];
      imm         = pm_data[3:0];
      alu_func    = pm_data[4:2];
      jmp_addr    = pm_data[3:0];
      case (r_state)
         S_RESET, S_RUN: begin
            ld_en  = w_is_load | w_is_mov;
            alu_en = w_is_alu;
            jmp    = w_is_jmp;
            jmp_nz = w_is_jnz;
            if (r_state == S_RESET) begin
               w_state_nxt = S_RUN;
            end else if (w_self_jmp) begin
               w_state_nxt = S_HALT;
            end
         end
         S_HALT: begin
            // Keep redirecting the sequencer onto the current page
            jmp      = 1'b1;
            jmp_addr = pc[7:4];
         end
         default: begin
            w_state_nxt = S_RESET;
         end
      endcase
      if (!sync_reset_n) begin
         w_state_nxt = S_RESET;
         ld_en       = 1'b0;
         alu_en      = 1'b0;
         jmp         = 1'b0;
         jmp_nz      = 1'b0;
      end
   end

   // Zero flag: captures the ALU result, frozen in halt since alu_en is 0
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         r_flag <= 1'b1;
      end else if (alu_en) begin
         r_flag <= alu_zero;
      end
   end

   assign dont_jump = r_flag;
   assign halted    = (r_state == S_HALT);

`ifdef DECODER_STATS_EN
   logic [STAT_W-1:0] r_instr_count;
   logic [STAT_W-1:0] r_jump_count;
   logic              w_taken;

   assign w_taken = jmp | (jmp_nz & ~r_flag);

   // Saturating instruction and taken-jump counters, active only in RUN
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         r_instr_count <= '0;
         r_jump_count  <= '0;
      end else if (r_state == S_RUN) begin
         if (r_instr_count != {STAT_W{1'b1}}) begin
            r_instr_count <= r_instr_count + STAT_W'(1);
         end
         if (w_taken && (r_jump_count != {STAT_W{1'b1}})) begin
            r_jump_count <= r_jump_count + STAT_W'(1);
         end
      end
   end

   assign instr_count = r_instr_count;
   assign jump_count  = r_jump_count;
`else
   // STAT_W only sizes the optional counters
   if (STAT_W == 0) begin : g_no_stat_w
   end
`endif

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

- Decodes the 8-bit instruction from program memory into the sequencer's jump controls and the datapath enables.
- Owns the zero flag that drives `dont_jump`, and detects the jump-to-self halt idiom.
- Sits between the program memory output and `program_sequencer`; drives the register file and ALU selects.
- Jump controls are combinational from `pm_data`, so the sequencer redirects `pm_addr` in the same cycle.

## Interface

Parameters:
- `STAT_W`, 16: width of the statistics counters (used only with `DECODER_STATS_EN`).

Ports:
- `clk`  in  1  rising-edge clock.
- `sync_reset_n`  in  1  reset, synchronous and active-low.
- `pm_data`  in  8  instruction at address `pc`; program memory is registered on `clk`.
- `pc`  in  8  current program counter from `program_sequencer`.
- `alu_zero`  in  1  ALU result-is-zero, valid in the cycle `alu_en` is high.
- `jmp`  out  1  unconditional jump request.
- `jmp_nz`  out  1  conditional jump request.
- `jmp_addr`  out  4  jump target page; the target address is `{jmp_addr, 4'h0}`.
- `dont_jump`  out  1  registered zero flag.
- `ld_en`  out  1  register file write enable.
- `ld_sel`  out  3  destination register.
- `src_sel`  out  3  source register for MOV.
- `imm_sel`  out  1  1 = write `imm`, 0 = write the register at `src_sel`.
- `imm`  out  4  immediate value.
- `alu_en`  out  1  ALU operation this cycle.
- `alu_func`  out  3  ALU function code.
- `halted`  out  1  sticky halt indicator.
- `instr_count`  out  `STAT_W`  executed instructions (only with `DECODER_STATS_EN`).
- `jump_count`  out  `STAT_W`  taken jumps (only with `DECODER_STATS_EN`).

## Operation

Instruction encoding, `ir = pm_data`:
- `0ddd_iiii`: LOAD. `ld_en`=1, `ld_sel`=ddd, `imm_sel`=1, `imm`=iiii.
- `10dd_dsss`: MOV. `ld_en`=1, `ld_sel`=ddd, `src_sel`=sss, `imm_sel`=0.
- `110f_ff00`: ALU. `alu_en`=1, `alu_func`=fff.
- Any other `110x_xxxx`: NOP. All enables 0.
- `1110_aaaa`: JMP. `jmp`=1, `jmp_addr`=aaaa.
- `1111_aaaa`: JNZ. `jmp_nz`=1, `jmp_addr`=aaaa. The sequencer takes the jump only when `dont_jump`=0.

Select outputs:
- Outside their instruction, `ld_sel`, `src_sel`, `imm`, `alu_func` and `jmp_addr` carry the raw `ir` bit-fields.
- Their value is don't-care when the matching enable is 0.

Zero flag:
- On a clock edge with `alu_en`=1 and not halted, the flag loads `alu_zero`.
- Otherwise the flag holds.
- `dont_jump` is the flag itself.
- JNZ therefore sees the result of the most recent completed ALU operation.

State machine:
- `RESET`: held while `sync_reset_n`=0. All enables, `jmp` and `jmp_nz` are forced to 0. The flag is set to 1 and `halted` to 0.
- `RESET` → `RUN` on the first edge with `sync_reset_n`=1.
- `RUN`: normal decode.
- `RUN` → `HALT` on an edge where `ir` is JMP and `{jmp_addr, 4'h0} == pc`.
- `HALT`:
  - `halted`=1, `jmp`=1 and `jmp_addr`=`pc[7:4]`, so the pc stays put.
  - `ld_en`, `alu_en` and `jmp_nz` are 0.
  - The flag is frozen.
  - The only exit is reset.
- A JNZ to self does not halt.

## Timing

- Decode is zero latency: every output except `dont_jump` and `halted` is combinational from `pm_data`, gated by state.
- `dont_jump` updates one edge after the ALU instruction.
  - An ALU instruction immediately followed by JNZ uses the new flag.
  - A JNZ in the same cycle as an ALU instruction is impossible, since each instruction is one opcode.
- In the cycle of the halting JMP, outputs decode normally (`jmp`=1). `halted` rises on the next edge.
- Reset values after an edge with `sync_reset_n`=0:
  - `dont_jump`=1, `halted`=0.
  - All combinational enables are 0 while reset is low.
  - Counters are 0.
- Reset asserted mid-program (including in `HALT`) takes effect at the next edge, regardless of the current instruction.

## Configuration

- `DECODER_STATS_EN` defined:
  - `instr_count` increments on every edge in `RUN`.
  - `jump_count` increments on every edge in `RUN` where `jmp`=1, or where `jmp_nz`=1 and `dont_jump`=0.
  - Both counters saturate at all-ones and clear on reset.
  - Neither counter counts in `HALT`.
- `DECODER_STATS_EN` undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan

- Reset release, `pm_data`=0x35 → `ld_en`=1, `ld_sel`=3, `imm`=5, `imm_sel`=1, in the same cycle. During reset, `ld_en`=0 and `dont_jump`=1.
- `pm_data`=0x9A → MOV: `ld_sel`=3, `src_sel`=2, `imm_sel`=0. Then `pm_data`=0xC4 → `alu_en`=1, `alu_func`=1. Then 0xC5 → all enables 0.
- ALU with `alu_zero`=0, next instruction 0xF3 → `dont_jump`=0, `jmp_nz`=1, `jmp_addr`=3. Repeat with `alu_zero`=1 → `dont_jump`=1.
- `pc`=0x20, `pm_data`=0xE2 → `jmp`=1, then `halted`=1 next cycle. Later `pm_data`=0x35 → `ld_en` stays 0, `jmp_addr`=2. Assert `sync_reset_n`=0 → `halted`=0.
- `pc`=0x20, `pm_data`=0xF2 with `dont_jump`=0 → no halt; `halted` stays 0.
- With `DECODER_STATS_EN`: 10 instructions including 2 JMP and 1 untaken JNZ → `instr_count`=10, `jump_count`=2. Force `STAT_W`=4 and run 20 cycles → `instr_count` holds at 15.
